// File: rtl/bus_timer_irq_if.sv
// bus_timer_irq_if -- microcpu byte-bus connection between the CPU and the timer.
//   read     CPU -> timer  1 = read/idle, 0 = one-cycle write strobe
//   address  CPU -> timer  byte address
//   wdata    CPU -> timer  write data (CPU dout)
//   rdata    timer -> CPU  registered read data (to CPU din via mux)
//   hit      timer -> CPU  registered: rdata belongs to this block
//   intr     timer -> CPU  interrupt request
interface bus_timer_irq_if;
    logic        read;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        hit;
    logic        intr;

    modport master (output read, address, wdata, input rdata, hit, intr);
    modport slave  (input read, address, wdata, output rdata, hit, intr);
endinterface

// File: rtl/bus_timer_irq.sv
// bus_timer_irq -- memory-mapped 16-bit down-counter timer with prescaler and
// interrupt flag, responding on the microcpu byte bus.
//   clk  rising-edge clock (the CPU works on the falling edge)
//   rst  asynchronous active-high reset
//   bus  slave side of bus_timer_irq_if (read/address/wdata in,
//        rdata/hit/intr out)
// Register window: 8 bytes at BASE (8-byte aligned); ID returned at BASE+7.
module bus_timer_irq #(
    parameter logic [15:0] BASE = 16'hFF00,
    parameter logic [7:0]  ID   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    bus_timer_irq_if.slave   bus
);
    logic [15:0] cnt, rld;
    logic [7:0]  snap_h, rld_stg, pre, pcnt;
    logic        en, ie, auto_rld, if_f, ovr_f;
    logic [7:0]  rd_mux;

    logic       in_win, we;
    logic [2:0] off;
    logic       wr_rldl, wr_rldh, wr_ctrl, wr_pre, wr_stat;
    logic       tick_raw, tick, uf, if_clr, ovr_clr;

    assign in_win  = (bus.address[15:3] == BASE[15:3]);
    assign off     = bus.address[2:0];
    assign we      = !bus.read && in_win;
    assign wr_rldl = we && (off == 3'd2);
    assign wr_rldh = we && (off == 3'd3);
    assign wr_ctrl = we && (off == 3'd4);
    assign wr_pre  = we && (off == 3'd5);
    assign wr_stat = we && (off == 3'd6);

    // A reload write or a disabling CTRL write swallows a coincident tick.
    assign tick_raw = en && (pcnt == pre);
    assign tick     = tick_raw && !wr_rldh && !(wr_ctrl && !bus.wdata[0]);
    assign uf       = tick && (cnt == 16'd0);
    assign if_clr   = wr_stat && bus.wdata[0];
    assign ovr_clr  = wr_stat && bus.wdata[1];

    // intr is a plain AND of two flops, so it cannot glitch and drops with rst.
    assign bus.intr = if_f & ie;

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            3'd0: rd_mux = cnt[7:0];
            3'd1: rd_mux = snap_h;
            3'd2: rd_mux = rld[7:0];
            3'd3: rd_mux = rld[15:8];
            3'd4: rd_mux = {5'b0, auto_rld, ie, en};
            3'd5: rd_mux = pre;
            3'd6: rd_mux = {6'b0, ovr_f, if_f};
            3'd7: rd_mux = ID;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata <= 8'h00;
            bus.hit   <= 1'b0;
            cnt       <= 16'h0000;
            snap_h    <= 8'h00;
            rld       <= 16'h0000;
            rld_stg   <= 8'h00;
            en        <= 1'b0;
            ie        <= 1'b0;
            auto_rld  <= 1'b0;
            pre       <= 8'h00;
            pcnt      <= 8'h00;
            if_f      <= 1'b0;
            ovr_f     <= 1'b0;
        end else begin
            bus.hit   <= in_win;
            bus.rdata <= in_win ? rd_mux : 8'h00;

            // Any read cycle at offset 0 (fetches included) snapshots the high byte.
            if (in_win && bus.read && (off == 3'd0))
                snap_h <= cnt[15:8];

            if (wr_rldl)
                rld_stg <= bus.wdata;

            if (wr_rldh) begin
                rld <= {bus.wdata, rld_stg};
                cnt <= {bus.wdata, rld_stg};
            end else if (tick) begin
                if (cnt != 16'd0) cnt <= cnt - 16'd1;
                else              cnt <= auto_rld ? rld : 16'h0000;
            end

            // Prescaler restarts on reload, on enable/disable, while stopped and after each tick.
            if (wr_rldh || (wr_ctrl && !(en && bus.wdata[0])) || !en || tick_raw)
                pcnt <= 8'h00;
            else
                pcnt <= pcnt + 8'd1;

            // An explicit CTRL write wins over the one-shot auto-disable.
            if (wr_ctrl)
                {auto_rld, ie, en} <= bus.wdata[2:0];
            else if (uf && !auto_rld)
                en <= 1'b0;

            if (wr_pre)
                pre <= bus.wdata;

            // Underflow set beats W1C; OVR only if the old IF survives this cycle.
            if_f  <= uf | (if_f & !if_clr);
            ovr_f <= (uf & if_f & !if_clr) | (ovr_f & !ovr_clr);
        end
    end
endmodule

// File: tb/tb_bus_timer_irq.sv
module tb_bus_timer_irq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bus_timer_irq_if bus();

    bus_timer_irq #(.BASE(16'hFF00), .ID(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both tasks start and end on a falling edge, like the CPU.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.read    = 1'b0;
        bus.address = a;
        bus.wdata   = d;
        @(negedge clk);
        bus.read    = 1'b1;
        bus.address = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.read    = 1'b1;
        bus.address = a;
        @(negedge clk);
    endtask

    task automatic step();
        bus.read    = 1'b1;
        bus.address = 16'h0000;
        @(negedge clk);
    endtask

    initial begin
        bus.read    = 1'b1;
        bus.address = 16'h0000;
        bus.wdata   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_intr", 16'(bus.intr), 16'h0);
        check("rst_hit", 16'(bus.hit), 16'h0);
        check("rst_rdata", 16'(bus.rdata), 16'h00);
        rst = 1'b0;
        @(negedge clk);

        // ID, CTRL and an out-of-window read
        rd(16'hFF07); check("id", 16'(bus.rdata), 16'hA5); check("id_hit", 16'(bus.hit), 16'h1);
        rd(16'hFF04); check("ctrl_rst", 16'(bus.rdata), 16'h00); check("ctrl_hit", 16'(bus.hit), 16'h1);
        rd(16'hFEFF); check("miss_hit", 16'(bus.hit), 16'h0); check("miss_data", 16'(bus.rdata), 16'h00);

        // Auto-reload: RLD=3, PRE=1 -> underflow every 8 clocks
        wr(16'hFF02, 8'h03); wr(16'hFF03, 8'h00); wr(16'hFF05, 8'h01);
        wr(16'hFF04, 8'h07);                         // enable edge P0, now at N0
        for (int i = 1; i <= 7; i++) begin
            step(); check($sformatf("auto_lo%0d", i), 16'(bus.intr), 16'h0);
        end
        step(); check("auto_first", 16'(bus.intr), 16'h1);   // N8
        rd(16'hFF00); check("auto_reload", 16'(bus.rdata), 16'h03); // N9
        repeat (5) step();                                    // N14
        rd(16'hFF06); check("stat_if", 16'(bus.rdata), 16'h01); // N15
        rd(16'hFF06);                                         // N16
        rd(16'hFF06); check("stat_ovr", 16'(bus.rdata), 16'h03); // N17
        check("intr_held", 16'(bus.intr), 16'h1);
        wr(16'hFF06, 8'h01); check("w1c_if_intr", 16'(bus.intr), 16'h0); // N18
        rd(16'hFF06); check("w1c_if", 16'(bus.rdata), 16'h02);           // N19
        wr(16'hFF06, 8'h02);                                             // N20
        rd(16'hFF06); check("w1c_ovr", 16'(bus.rdata), 16'h00);          // N21
        repeat (3) step(); check("auto_third", 16'(bus.intr), 16'h1);    // N24

        // Asynchronous reset mid-count
        #2 rst = 1'b1;
        #1 check("async_rst_intr", 16'(bus.intr), 16'h0);
        @(negedge clk); rst = 1'b0;
        rd(16'hFF04); check("ctrl_after_rst", 16'(bus.rdata), 16'h00);

        // One-shot: RLD=2, PRE=0 -> underflow 3 clocks after enable, EN cleared
        wr(16'hFF02, 8'h02); wr(16'hFF03, 8'h00); wr(16'hFF05, 8'h00);
        wr(16'hFF04, 8'h03);
        step(); check("os_lo1", 16'(bus.intr), 16'h0);
        step(); check("os_lo2", 16'(bus.intr), 16'h0);
        step(); check("os_hi", 16'(bus.intr), 16'h1);
        rd(16'hFF04); check("os_ctrl", 16'(bus.rdata), 16'h02);
        repeat (4) step();
        rd(16'hFF00); check("os_cnt_l", 16'(bus.rdata), 16'h00);
        rd(16'hFF06); check("os_stat", 16'(bus.rdata), 16'h01);

        // Snapshot of the high byte on CNT_L read
        wr(16'hFF02, 8'h34); wr(16'hFF03, 8'h12);
        rd(16'hFF00); check("snap_lo", 16'(bus.rdata), 16'h34);
        wr(16'hFF03, 8'h56);
        rd(16'hFF01); check("snap_hi", 16'(bus.rdata), 16'h12);
        rd(16'hFF00); rd(16'hFF01); check("snap_new", 16'(bus.rdata), 16'h56);
        rd(16'hFF03); check("rld_h", 16'(bus.rdata), 16'h56);

        // Ignored writes: ID and outside the window
        wr(16'hFF07, 8'h00); rd(16'hFF07); check("id_ro", 16'(bus.rdata), 16'hA5);
        wr(16'hFF0C, 8'h07); rd(16'hFF04); check("ctrl_outside", 16'(bus.rdata), 16'h02);

        // Underflow coincident with W1C of IF: RLD=1, PRE=0, period 2
        wr(16'hFF06, 8'h03);
        wr(16'hFF02, 8'h01); wr(16'hFF03, 8'h00); wr(16'hFF04, 8'h07); // P0 -> N0
        step(); step(); check("co_intr", 16'(bus.intr), 16'h1);          // N2
        step();                                                          // N3
        wr(16'hFF06, 8'h01); check("co_intr_kept", 16'(bus.intr), 16'h1); // edge P4 = underflow
        rd(16'hFF06); check("co_stat", 16'(bus.rdata), 16'h01);

        // RLD_H write coincident with an underflowing tick
        wr(16'hFF04, 8'h00); wr(16'hFF06, 8'h03);
        wr(16'hFF02, 8'h00); wr(16'hFF03, 8'h00);   // CNT = 0
        wr(16'hFF02, 8'h07);
        wr(16'hFF04, 8'h05);                        // EN|AUTO, no IE
        wr(16'hFF03, 8'h00);                        // tick with CNT=0 here
        rd(16'hFF06); check("rldh_no_if", 16'(bus.rdata), 16'h00);
        rd(16'hFF00); check("rldh_cnt", 16'(bus.rdata), 16'h06);
        check("rldh_intr", 16'(bus.intr), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
